ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_pkg.sv | 24 ++
 rtl/ram_port_arbiter_arb_rr2.sv | 30 +++
 rtl/ram_port_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Shared definitions for the two-port RAM arbiter.
// Contents:
//   DEFAULT_ADDR_W / DEFAULT_DATA_W : default RAM address and data widths
//   PORT_FETCH / PORT_DATA          : port identifiers, also used as bit
//                                     positions in request/grant vectors
//   state_e                         : arbiter FSM state encoding
package ram_port_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 8;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ1  = 3'd1,
        ST_READ2  = 3'd2,
        ST_WRITE1 = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/ram_port_arbiter_arb_rr2.sv
// arb_rr2
// Combinational two-way round-robin arbiter.
// Ports:
//   req        in  [1:0]  request bits, indexed by port ID
//   last_grant in  1      port ID that won the previous grant
//   grant      out [1:0]  one-hot grant, indexed by port ID (zero if no request)
module arb_rr2
    import ram_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the port that did not win
    // last time is chosen so neither port can starve the other.
    always_comb begin
        grant = 2'b00;
        if (req[PORT_FETCH] && req[PORT_DATA]) begin
            if (last_grant == PORT_DATA) begin
                grant[PORT_FETCH] = 1'b1;
            end else begin
                grant[PORT_DATA] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one synchronous single-port RAM between a read-only fetch port
// (stage12) and a read/write data port (stage3). One access at a time;
// every output is registered.
// Ports:
//   ram_clk, rst               clock; synchronous active-low reset
//   stage12_read/_address      fetch read request (level) and address
//   stage12_read_ready/_data_out   fetch completion pulse and held read data
//   stage3_req/_write/_address/_write_data   data-port request, direction,
//                                            address and write data
//   stage3_ready/_read_data_out    data-port completion pulse and held read data
//   ram_write_enable/_address/_data_in       RAM control outputs
//   ram_data_out               registered RAM read data
//   busy                       high whenever an access is in progress
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              ram_clk,
    input  logic              rst,
    input  logic              stage12_read,
    input  logic [ADDR_W-1:0] stage12_read_address,
    output logic              stage12_read_ready,
    output logic [DATA_W-1:0] stage12_read_data_out,
    input  logic              stage3_req,
    input  logic              stage3_write,
    input  logic [ADDR_W-1:0] stage3_address,
    input  logic [DATA_W-1:0] stage3_write_data,
    output logic              stage3_ready,
    output logic [DATA_W-1:0] stage3_read_data_out,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              grant_port_q, grant_port_d;
    logic              last_grant_q, last_grant_d;
    logic              stage12_read_ready_q, stage12_read_ready_d;
    logic [DATA_W-1:0] stage12_read_data_q, stage12_read_data_d;
    logic              stage3_ready_q, stage3_ready_d;
    logic [DATA_W-1:0] stage3_read_data_q, stage3_read_data_d;
    logic              ram_write_enable_q, ram_write_enable_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              busy_q, busy_d;

    logic [1:0] req;
    logic [1:0] grant;

    always_comb begin
        req             = 2'b00;
        req[PORT_FETCH] = stage12_read;
        req[PORT_DATA]  = stage3_req;
    end

    arb_rr2 u_arb_rr2 (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Next-state logic. Ready pulses and the write strobe default low so
    // they last exactly one cycle; address, write data and read-data
    // registers default to holding their value.
    always_comb begin
        state_d              = state_q;
        grant_port_d         = grant_port_q;
        last_grant_d         = last_grant_q;
        stage12_read_ready_d = 1'b0;
        stage12_read_data_d  = stage12_read_data_q;
        stage3_ready_d       = 1'b0;
        stage3_read_data_d   = stage3_read_data_q;
        ram_write_enable_d   = 1'b0;
        ram_address_d        = ram_address_q;
        ram_data_in_d        = ram_data_in_q;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    grant_port_d = grant[PORT_DATA];
                    last_grant_d = grant[PORT_DATA];
                    if (grant[PORT_DATA]) begin
                        ram_address_d = stage3_address;
                        if (stage3_write) begin
                            ram_write_enable_d = 1'b1;
                            ram_data_in_d      = stage3_write_data;
                            state_d            = ST_WRITE1;
                        end else begin
                            state_d = ST_READ1;
                        end
                    end else begin
                        ram_address_d = stage12_read_address;
                        state_d       = ST_READ1;
                    end
                end
            end

            // RAM samples the address at this edge.
            ST_READ1: begin
                state_d = ST_READ2;
            end

            // RAM output now reflects the sampled address.
            ST_READ2: begin
                if (grant_port_q == PORT_DATA) begin
                    stage3_read_data_d = ram_data_out;
                    stage3_ready_d     = 1'b1;
                end else begin
                    stage12_read_data_d  = ram_data_out;
                    stage12_read_ready_d = 1'b1;
                end
                state_d = ST_DONE;
            end

            // RAM performs the write at this edge.
            ST_WRITE1: begin
                stage3_ready_d = 1'b1;
                state_d        = ST_DONE;
            end

            // Requests are ignored here; a request still held in IDLE is
            // treated as a fresh access.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register. Reset abandons any in-flight access without a
    // ready pulse; fetch wins the first tie because last_grant starts at
    // the data port.
    always_ff @(posedge ram_clk) begin
        if (!rst) begin
            state_q              <= ST_IDLE;
            grant_port_q         <= PORT_FETCH;
            last_grant_q         <= PORT_DATA;
            stage12_read_ready_q <= 1'b0;
            stage12_read_data_q  <= '0;
            stage3_ready_q       <= 1'b0;
            stage3_read_data_q   <= '0;
            ram_write_enable_q   <= 1'b0;
            ram_address_q        <= '0;
            ram_data_in_q        <= '0;
            busy_q               <= 1'b0;
        end else begin
            state_q              <= state_d;
            grant_port_q         <= grant_port_d;
            last_grant_q         <= last_grant_d;
            stage12_read_ready_q <= stage12_read_ready_d;
            stage12_read_data_q  <= stage12_read_data_d;
            stage3_ready_q       <= stage3_ready_d;
            stage3_read_data_q   <= stage3_read_data_d;
            ram_write_enable_q   <= ram_write_enable_d;
            ram_address_q        <= ram_address_d;
            ram_data_in_q        <= ram_data_in_d;
            busy_q               <= busy_d;
        end
    end

    assign stage12_read_ready    = stage12_read_ready_q;
    assign stage12_read_data_out = stage12_read_data_q;
    assign stage3_ready          = stage3_ready_q;
    assign stage3_read_data_out  = stage3_read_data_q;
    assign ram_write_enable      = ram_write_enable_q;
    assign ram_address           = ram_address_q;
    assign ram_data_in           = ram_data_in_q;
    assign busy                  = busy_q;

endmodule
